// File: rtl/traffic_pkg.sv
// Shared types and constants for the multi-approach traffic phase controller.
// State encoding, timer interval codes and LED field offsets live here so the
// controller and its helpers agree on them.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_GRN_BASE,
        ST_GRN_EXT,
        ST_YEL,
        ST_WALK
    } state_e;

    localparam logic [1:0] IV_BASE = 2'd0;
    localparam logic [1:0] IV_EXT  = 2'd1;
    localparam logic [1:0] IV_YEL  = 2'd2;
    localparam logic [1:0] IV_WALK = 2'd3;

    localparam int LED_R = 2;
    localparam int LED_Y = 1;
    localparam int LED_G = 0;

    // Timer interval that a state requests when it is entered.
    function automatic logic [1:0] state_interval(state_e s);
        case (s)
            ST_GRN_EXT: return IV_EXT;
            ST_YEL:     return IV_YEL;
            ST_WALK:    return IV_WALK;
            default:    return IV_BASE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_next_phase.sv
// Combinational selector for the approach that gets the next green.
// Build option DEMAND_SKIP_EN: when defined, approaches without vehicle demand
// are skipped (the main road, phase 0, is never skipped); when undefined the
// order is strict round-robin.
module traffic_next_phase #(
    parameter int N_PHASE = 2,
    parameter int PW      = $clog2(N_PHASE)
) (
    input  logic [PW-1:0]      phase_i,
    input  logic [N_PHASE-1:0] sensor_i,
    output logic [PW-1:0]      next_phase_o
);

`ifdef DEMAND_SKIP_EN
    // Phase 0 never carries a skip decision, so its sensor bit is not needed here.
    logic unused_sensor0;
    assign unused_sensor0 = sensor_i[0];

    // Lowest-numbered demanding approach above the current one, else the main road.
    always_comb begin
        next_phase_o = '0;
        for (int i = N_PHASE - 1; i >= 1; i--) begin
            if (i > int'(phase_i) && sensor_i[i]) begin
                next_phase_o = PW'(i);
            end
        end
    end
`else
    // Sensors only drive green extension in this build.
    logic unused_sensor;
    assign unused_sensor = ^sensor_i;

    // Strict round-robin with wrap from the last approach to the main road.
    always_comb begin
        if (int'(phase_i) >= N_PHASE - 1) begin
            next_phase_o = '0;
        end else begin
            next_phase_o = phase_i + PW'(1);
        end
    end
`endif

endmodule

// File: rtl/traffic_phase_fsm.sv
// Traffic phase controller: walks N_PHASE approaches through green, an optional
// single sensor extension and yellow, inserting a pedestrian walk phase when a
// request is latched. Talks to an external interval timer and drives the LEDs.
// Optional build macro DEMAND_SKIP_EN (see traffic_next_phase) enables skipping
// approaches without demand.
module traffic_phase_fsm #(
    parameter int N_PHASE = 2,
    parameter int LED_W   = 3 * N_PHASE + 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_PHASE-1:0]         sensor_sync,
    input  logic                       wr,
    input  logic                       prog_sync,
    input  logic                       expired,
    output logic                       wr_reset,
    output logic [1:0]                 interval,
    output logic                       start_timer,
    output logic [$clog2(N_PHASE)-1:0] phase,
    output logic [LED_W-1:0]           led
);
    import traffic_pkg::*;

    localparam int PW = $clog2(N_PHASE);

    function automatic logic [LED_W-1:0] all_red_led();
        logic [LED_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_PHASE; i++) begin
            v[3*i+LED_R] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [LED_W-1:0] LED_ALL_RED = all_red_led();

    state_e           state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [PW-1:0]    next_phase;
    logic             walk_pending_q, walk_pending_d;
    logic             start_timer_q, start_timer_d;
    logic             wr_reset_q, wr_reset_d;
    logic [1:0]       interval_q, interval_d;
    logic [LED_W-1:0] led_q, led_d;
    logic             timer_done;
    logic             walk_entry;

    // An expiry seen while the timer is being (re)started belongs to the old interval.
    assign timer_done = expired && !start_timer_q;
    assign walk_entry = (state_q == ST_WALK) && wr_reset_q;

    traffic_next_phase #(
        .N_PHASE (N_PHASE),
        .PW      (PW)
    ) u_next_phase (
        .phase_i      (phase_q),
        .sensor_i     (sensor_sync),
        .next_phase_o (next_phase)
    );

    // Next state, active approach, walk latch and timer request.
    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        interval_d     = interval_q;
        start_timer_d  = 1'b0;
        wr_reset_d     = 1'b0;
        walk_pending_d = walk_entry ? 1'b0 : (walk_pending_q || wr);

        if (prog_sync && (state_q != ST_INIT)) begin
            state_d = ST_INIT;
            phase_d = '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    state_d = ST_GRN_BASE;
                    phase_d = '0;
                end
                ST_GRN_BASE: begin
                    if (timer_done) begin
                        state_d = sensor_sync[phase_q] ? ST_GRN_EXT : ST_YEL;
                    end
                end
                ST_GRN_EXT: begin
                    if (timer_done) begin
                        state_d = ST_YEL;
                    end
                end
                ST_YEL: begin
                    if (timer_done) begin
                        if (walk_pending_q) begin
                            state_d = ST_WALK;
                        end else begin
                            state_d = ST_GRN_BASE;
                            phase_d = next_phase;
                        end
                    end
                end
                ST_WALK: begin
                    if (timer_done) begin
                        state_d = ST_GRN_BASE;
                        phase_d = next_phase;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                    phase_d = '0;
                end
            endcase
        end

        if (state_d == ST_INIT) begin
            interval_d = IV_BASE;
        end else if (state_d != state_q) begin
            start_timer_d = 1'b1;
            interval_d    = state_interval(state_d);
        end

        wr_reset_d = (state_d == ST_WALK) && (state_q != ST_WALK);
    end

    // LED pattern for the state and approach being entered.
    always_comb begin
        led_d = '0;
        for (int i = 0; i < N_PHASE; i++) begin
            if (i == int'(phase_d) && (state_d == ST_GRN_BASE || state_d == ST_GRN_EXT)) begin
                led_d[3*i+LED_G] = 1'b1;
            end else if (i == int'(phase_d) && state_d == ST_YEL) begin
                led_d[3*i+LED_Y] = 1'b1;
            end else begin
                led_d[3*i+LED_R] = 1'b1;
            end
        end
        led_d[3*N_PHASE] = (state_d == ST_WALK);
    end

    // Controller state and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            phase_q        <= '0;
            walk_pending_q <= 1'b0;
            start_timer_q  <= 1'b0;
            wr_reset_q     <= 1'b0;
            interval_q     <= IV_BASE;
            led_q          <= LED_ALL_RED;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            walk_pending_q <= walk_pending_d;
            start_timer_q  <= start_timer_d;
            wr_reset_q     <= wr_reset_d;
            interval_q     <= interval_d;
            led_q          <= led_d;
        end
    end

    assign phase       = phase_q;
    assign interval    = interval_q;
    assign start_timer = start_timer_q;
    assign wr_reset    = wr_reset_q;
    assign led         = led_q;

endmodule

// File: tb/tb_traffic_phase_fsm.sv
// Self-checking bench for traffic_phase_fsm with three approaches. A behavioural
// model of the phase sequence runs alongside the DUT and every cycle's outputs
// are compared; directed scenarios cover walk requests, reprogramming and reset.
module tb_traffic_phase_fsm;

    localparam int N  = 3;
    localparam int LW = 3 * N + 1;

    localparam int K_INIT = 0;
    localparam int K_BASE = 1;
    localparam int K_EXT  = 2;
    localparam int K_YEL  = 3;
    localparam int K_WALK = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  sensor_sync;
    logic          wr;
    logic          prog_sync;
    logic          expired;
    logic          wr_reset;
    logic [1:0]    interval;
    logic          start_timer;
    logic [1:0]    phase;
    logic [LW-1:0] led;

    int  mKind;
    int  mAge;
    int  mPhase;
    bit  mPending;

    int passCount = 0;
    int checkCount = 0;
    int cyc = 0;
    int wrResetPulses = 0;
    int phase1Green = 0;
    int walkLedCycles = 0;

    traffic_phase_fsm #(.N_PHASE(N)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .sensor_sync (sensor_sync),
        .wr          (wr),
        .prog_sync   (prog_sync),
        .expired     (expired),
        .wr_reset    (wr_reset),
        .interval    (interval),
        .start_timer (start_timer),
        .phase       (phase),
        .led         (led)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    // Counts a comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Which approach gets the next green, given the one that just finished.
    function automatic int modelNext(int p, logic [N-1:0] s);
`ifdef DEMAND_SKIP_EN
        for (int k = 1; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (c == 0 || s[c]) return c;
        end
        return 0;
`else
        return (p + 1) % N;
`endif
    endfunction

    // Expected LED vector: active approach green/yellow, every other one red.
    function automatic logic [LW-1:0] expLed(int kind, int p);
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (i == p && (kind == K_BASE || kind == K_EXT)) v = v | (LW'(1) << (3 * i));
            else if (i == p && kind == K_YEL)                v = v | (LW'(2) << (3 * i));
            else                                             v = v | (LW'(4) << (3 * i));
        end
        if (kind == K_WALK) v = v | (LW'(1) << (3 * N));
        return v;
    endfunction

    task automatic modelReset();
        mKind = K_INIT;
        mAge = 0;
        mPhase = 0;
        mPending = 1'b0;
    endtask

    // Advance the model by one clock using the inputs held during that cycle.
    task automatic modelStep(input logic [N-1:0] s, input logic w, input logic p, input logic e);
        int nk;
        int np;
        bit live;
        bit npend;
        nk = mKind;
        np = mPhase;
        live = e && !(mAge == 0 && mKind != K_INIT);
        npend = (mKind == K_WALK && mAge == 0) ? 1'b0 : (mPending | w);
        if (p && mKind != K_INIT) begin
            nk = K_INIT;
            np = 0;
        end else begin
            case (mKind)
                K_INIT: begin nk = K_BASE; np = 0; end
                K_BASE: if (live) nk = s[mPhase] ? K_EXT : K_YEL;
                K_EXT:  if (live) nk = K_YEL;
                K_YEL:  if (live) begin
                            if (mPending) nk = K_WALK;
                            else begin nk = K_BASE; np = modelNext(mPhase, s); end
                        end
                default: if (live) begin nk = K_BASE; np = modelNext(mPhase, s); end
            endcase
        end
        mAge = (nk != mKind) ? 0 : mAge + 1;
        mKind = nk;
        mPhase = np;
        mPending = npend;
    endtask

    task automatic compareAll();
        checkOutput("phase", 32'(phase), mPhase);
        checkOutput("interval", 32'(interval), (mKind == K_INIT) ? 0 : mKind - 1);
        checkOutput("start_timer", 32'(start_timer), 32'(mAge == 0 && mKind != K_INIT));
        checkOutput("wr_reset", 32'(wr_reset), 32'(mKind == K_WALK && mAge == 0));
        checkOutput("led", 32'(led), 32'(expLed(mKind, mPhase)));
        if (wr_reset) wrResetPulses++;
        if (led[3*N]) walkLedCycles++;
        if (phase == 2'd1 && led[3]) phase1Green++;
    endtask

    // One clock of stimulus: drive, let the DUT and model step, then compare.
    task automatic applyStimulus(input logic [N-1:0] s, input logic w, input logic p, input logic e);
        sensor_sync = s;
        wr = w;
        prog_sync = p;
        expired = e;
        @(posedge clock);
        modelStep(s, w, p, e);
        #1;
        compareAll();
        cyc++;
    endtask

    task automatic stepCadence(input logic [N-1:0] s, input logic w);
        applyStimulus(s, w, 1'b0, (cyc % 3) == 2);
    endtask

    function automatic bit atPoint(int kind, int ph, int minAge);
        return (mKind == kind) && (ph < 0 || mPhase == ph) && (mAge >= minAge);
    endfunction

    // Run with the normal expiry cadence until the model reaches a given point.
    task automatic runUntil(input int kind, input int ph, input int minAge,
                            input logic [N-1:0] s, input string tag);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 60 && !ok; k++) begin
            if (atPoint(kind, ph, minAge)) ok = 1'b1;
            else stepCadence(s, 1'b0);
        end
        if (!ok && atPoint(kind, ph, minAge)) ok = 1'b1;
        if (!ok) checkOutput({"wait_", tag}, 32'd0, 32'd1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_led"}, 32'(led), 32'h124);
        checkOutput({tag, "_start"}, 32'(start_timer), 32'd0);
        checkOutput({tag, "_wrreset"}, 32'(wr_reset), 32'd0);
        checkOutput({tag, "_interval"}, 32'(interval), 32'd0);
        checkOutput({tag, "_phase"}, 32'(phase), 32'd0);
    endtask

    initial begin
        int pulsesBefore;
        reset_n = 1'b0;
        sensor_sync = '0;
        wr = 1'b0;
        prog_sync = 1'b0;
        expired = 1'b0;
        modelReset();

        #12;
        checkResetValues("reset");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // First green of the main road right after reset release.
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("firstLed", 32'(led), 32'h121);
        checkOutput("firstStart", 32'(start_timer), 32'd1);
        checkOutput("firstInterval", 32'(interval), 32'd0);

        // No demand, no walk: plain base/yellow rotation.
        for (int k = 0; k < 24; k++) stepCadence(3'b000, 1'b0);
        checkOutput("noWalkYet", wrResetPulses, 32'd0);

        // Main-road demand: one extension per green.
        for (int k = 0; k < 30; k++) stepCadence(3'b001, 1'b0);

        // Single-cycle walk request during phase-1 green.
        runUntil(K_BASE, 1, 0, 3'b000, "p1green");
        stepCadence(3'b000, 1'b1);
        for (int k = 0; k < 24; k++) stepCadence(3'b000, 1'b0);
        checkOutput("walkServed", 32'(wrResetPulses > 0), 32'd1);
        checkOutput("walkLedSeen", 32'(walkLedCycles > 0), 32'd1);

        // Request held across WALK entry re-arms for the next yellow.
        runUntil(K_YEL, -1, 0, 3'b000, "yelHold");
        pulsesBefore = wrResetPulses;
        for (int k = 0; k < 40; k++) begin
            stepCadence(3'b000, 1'b1);
            if (mKind == K_WALK && mAge >= 1) break;
        end
        stepCadence(3'b000, 1'b1);
        for (int k = 0; k < 30; k++) stepCadence(3'b000, 1'b0);
        checkOutput("walkTwice", 32'(wrResetPulses - pulsesBefore >= 2), 32'd1);

        // Reprogramming beats a simultaneous expiry in the extension.
        runUntil(K_EXT, -1, 1, 3'b001, "ext");
        applyStimulus(3'b001, 1'b0, 1'b1, 1'b1);
        checkOutput("progInitLed", 32'(led), 32'h124);
        checkOutput("progInitStart", 32'(start_timer), 32'd0);
        applyStimulus(3'b001, 1'b0, 1'b0, 1'b0);
        checkOutput("progPhase", 32'(phase), 32'd0);
        checkOutput("progInterval", 32'(interval), 32'd0);
        checkOutput("progStart", 32'(start_timer), 32'd1);

        // Demand only on phase 2.
        phase1Green = 0;
        for (int k = 0; k < 40; k++) stepCadence(3'b100, 1'b0);
`ifdef DEMAND_SKIP_EN
        checkOutput("phase1Skipped", phase1Green, 32'd0);
`else
        checkOutput("phase1Served", 32'(phase1Green > 0), 32'd1);
`endif

        // Randomised traffic.
        for (int k = 0; k < 300; k++) begin
            applyStimulus(N'($urandom_range(0, 7)), $urandom_range(0, 7) == 0,
                          $urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0);
        end

        // Asynchronous reset in the middle of a yellow.
        runUntil(K_YEL, -1, 0, 3'b000, "yelReset");
        #2;
        reset_n = 1'b0;
        #1;
        checkResetValues("asyncReset");
        modelReset();
        @(posedge clock);
        #1;
        checkResetValues("heldReset");
        reset_n = 1'b1;
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b0);
        checkOutput("restartLed", 32'(led), 32'h121);
        for (int k = 0; k < 12; k++) stepCadence(3'b010, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/traffic_phase_fsm.md
Name: traffic_phase_fsm

Overview:
- Parametrised successor to the two-road traffic-light controller. Cycles N_PHASE approaches through green, optional sensor extension, and yellow, with a latched pedestrian walk request.
- Drives the external interval timer through start_timer, interval and expired, and drives a packed LED vector.
- Sits between the input synchronisers (sensor_sync, wr, prog_sync) and the timer and LED drivers.

Parameters:
- N_PHASE, 2, number of approaches; legal range 2..4. Phase 0 is the main road.
- LED_W, 3*N_PHASE+1, LED vector width. Derived; do not override.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sensor_sync  in  N_PHASE  per-phase vehicle-present level, already synchronised.
- wr  in  1  walk request, single- or multi-cycle level.
- prog_sync  in  1  synchronous restart after timer reprogramming; one-cycle pulse.
- expired  in  1  timer-expired pulse, one cycle.
- wr_reset  out  1  one-cycle pulse: walk request served; clears the external request latch.
- interval  out  2  timer select: 0 BASE, 1 EXT, 2 YEL, 3 WALK.
- start_timer  out  1  one-cycle timer start pulse.
- phase  out  clog2(N_PHASE)  index of the active phase.
- led  out  LED_W  bits [3i+2:3i] = {R,Y,G} of phase i; bit 3*N_PHASE = walk.

Behaviour:
- Reset (reset_n=0, asynchronous): state INIT, phase 0, walk_pending 0, start_timer 0, wr_reset 0, interval 0. led = all R bits 1, all Y/G bits 0, walk bit 0.
- All outputs are registered.
- States: INIT, GRN_BASE, GRN_EXT, YEL, WALK.
- Timer handshake:
  - On every state entry, start_timer=1 for exactly the first cycle in the new state, and interval = that state's code.
  - interval holds for the whole state.
  - expired is ignored in any cycle where start_timer=1.
- INIT: the cycle after reset release, go to GRN_BASE with phase 0.
- GRN_BASE on expired:
  - sensor_sync[phase]=1: go to GRN_EXT (one extension per green; no re-extension).
  - otherwise: go to YEL.
- GRN_EXT on expired: go to YEL.
- YEL on expired:
  - walk_pending=1: go to WALK.
  - otherwise: go to GRN_BASE with phase = next_phase.
- WALK on expired: go to GRN_BASE with phase = next_phase, where next_phase is computed from the phase that preceded WALK.
- next_phase: (phase+1) mod N_PHASE; N_PHASE-1 wraps to 0.
- LEDs:
  - Active phase: G lit in GRN_*, Y lit in YEL.
  - All other phases: R lit.
  - WALK: all R lit plus the walk bit.
- walk_pending:
  - Set on any cycle with wr=1.
  - Cleared on the WALK entry cycle; clear wins over a simultaneous wr.
  - wr=1 during later WALK cycles re-sets it, to be served at the next yellow.
- wr_reset: 1 on the WALK entry cycle only, coincident with start_timer.
- prog_sync=1 in any state except INIT: go to INIT next cycle, then GRN_BASE phase 0. walk_pending is retained. prog_sync has priority over a simultaneous expired.
- Reset mid-operation: immediate return to the reset values; any in-flight timer start is lost.
- expired in INIT: ignored.

Optional Feature:
- Macro: DEMAND_SKIP_EN.
- Defined: next_phase is the first phase after the current one (cyclic order) whose sensor_sync bit is 1, sampled in the YEL/WALK exit cycle.
  - Phase 0 is never skipped.
  - If no phase from phase+1 to N_PHASE-1 has demand, next_phase = 0.
- Undefined: strict round-robin; sensor_sync is used only for green extension.

Decomposition:
- Package traffic_pkg:
  - state enum.
  - interval codes IV_BASE/IV_EXT/IV_YEL/IV_WALK.
  - LED field offsets: R=2, Y=1, G=0.
- Sub-module traffic_next_phase: combinational next-phase selector over current phase and sensor_sync; contains the DEMAND_SKIP_EN logic.

Test Plan:
- Bench configuration: N_PHASE=3; the bench pulses expired 1 cycle every 3 cycles.
- Reset release, sensor_sync=0 -> start_timer pulses with interval 0,2,0,2,0,2. phase goes 0,1,2,0. led phase0 = 001 in GRN_BASE, then 010 in YEL; walk bit 0; wr_reset never pulses.
- sensor_sync=3'b001 constant -> phase 0 gets interval sequence 0,1,2. Phases 1 and 2 get 0,2. No second extension.
- wr one-cycle pulse during phase-1 green -> after phase-1 YEL: interval 3, wr_reset=1 for 1 cycle, led = all R plus walk bit. Then GRN_BASE with phase 2.
- wr held high across WALK entry -> wr_reset pulses. walk_pending is re-set, so WALK is entered again after the next yellow.
- prog_sync together with expired in GRN_EXT -> INIT (all R) for 1 cycle, then GRN_BASE with phase 0 and interval 0.
- DEMAND_SKIP_EN defined, sensor_sync=3'b100 -> phase order 0,2,0; phase 1 never green.
- reset_n low mid-YEL -> outputs immediately at reset values, asynchronously, without waiting for a clock edge.
